// File: rtl/alu_exec_seq_pkg.sv
// Shared definitions for the ALU execute sequencer.
// Holds the ALU opcode codes (identical to the ALU's), the sequencer FSM
// encoding, the status-flag bit positions and the latched-instruction record.
package alu_exec_seq_pkg;

  localparam int DATA_W  = 8;
  localparam int REG_CNT = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  // Bit positions inside the {N, C, Z} status register
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  typedef struct packed {
    logic [2:0]        op;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic [1:0]        rt;
    logic              imm_en;
    logic [DATA_W-1:0] imm;
    logic              wb_en;
  } instr_t;

endpackage

// File: rtl/alu_exec_seq_regfile_4x8.sv
// 4x8 general register file.
// Ports: clk/rst (async, active-high, clears all registers); two combinational
// read ports (ra_*, rb_*); one synchronous write port (we, wsel, wdata);
// combinational debug read port (dbg_sel -> dbg_data). Reads see the state
// after the most recent edge; there is no write-to-read bypass.
module regfile_4x8
  import alu_exec_seq_pkg::*;
#(
  parameter int NREGS = REG_CNT,
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ra_sel,
  output logic [WIDTH-1:0] ra_data,
  input  logic [1:0]       rb_sel,
  output logic [WIDTH-1:0] rb_data,
  input  logic             we,
  input  logic [1:0]       wsel,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  logic [NREGS-1:0][WIDTH-1:0] regs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (we) begin
      regs[wsel] <= wdata;
    end
  end

  assign ra_data  = regs[ra_sel];
  assign rb_data  = regs[rb_sel];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_exec_seq.sv
// Multi-cycle execute sequencer in front of the 8-bit ALU.
// One instruction per valid/ready handshake, four cycles each:
//   IDLE (accept) -> READ (fetch operands) -> EXEC (drive ALU, capture result)
//   -> WB (done=1; write rd if wb_en, always update flags).
// Ports: instr_* handshake and fields in; alu_a/alu_b/alu_op out to the ALU and
// alu_result/alu_zero/alu_carry/alu_negative back; flags = {N,C,Z}; done pulse
// during WB; dbg_sel/dbg_data combinational register peek.
// Reset is asynchronous active-high and aborts any instruction in flight.
module alu_exec_seq
  import alu_exec_seq_pkg::*;
#(
  parameter int NREGS = REG_CNT,
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [1:0]       instr_rd,
  input  logic [1:0]       instr_rs,
  input  logic [1:0]       instr_rt,
  input  logic             instr_imm_en,
  input  logic [WIDTH-1:0] instr_imm,
  input  logic             instr_wb_en,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_negative,
  output logic [2:0]       flags,
  output logic             done,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  state_e           state;
  instr_t           ir;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH-1:0] res;
  logic [2:0]       res_flags;
  logic [WIDTH-1:0] rs_data, rt_data;

  // Writeback happens on the edge leaving WB; the write enable decodes from
  // the registered state so it is glitch-free and aborted cleanly by reset.
  regfile_4x8 #(.NREGS(NREGS), .WIDTH(WIDTH)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .ra_sel   (ir.rs),
    .ra_data  (rs_data),
    .rb_sel   (ir.rt),
    .rb_data  (rt_data),
    .we       (state == WB && ir.wb_en),
    .wsel     (ir.rd),
    .wdata    (res),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  // Operand registers feed the ALU directly; they only change in READ, so
  // they are stable for the whole EXEC cycle.
  assign alu_a  = opa;
  assign alu_b  = opb;
  assign alu_op = ir.op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ir          <= '0;
      opa         <= '0;
      opb         <= '0;
      res         <= '0;
      res_flags   <= '0;
      flags       <= '0;
      done        <= 1'b0;
      instr_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // ready is registered, so it stays low during reset and for the
          // first cycle after release.
          if (instr_valid && instr_ready) begin
            ir          <= '{op: instr_op, rd: instr_rd, rs: instr_rs,
                             rt: instr_rt, imm_en: instr_imm_en,
                             imm: instr_imm, wb_en: instr_wb_en};
            instr_ready <= 1'b0;
            state       <= READ;
          end else begin
            instr_ready <= 1'b1;
          end
        end
        READ: begin
          // Sources are read before any writeback, so rd==rs/rt sees old data.
          opa   <= rs_data;
          opb   <= ir.imm_en ? ir.imm : rt_data;
          state <= EXEC;
        end
        EXEC: begin
          res                <= alu_result;
          res_flags[FLAG_Z]  <= alu_zero;
          res_flags[FLAG_C]  <= alu_carry;
          res_flags[FLAG_N]  <= alu_negative;
          done               <= 1'b1;
          state              <= WB;
        end
        WB: begin
          flags       <= res_flags;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Randomised scoreboard bench for alu_exec_seq. The bench also plays the role
// of the external ALU. A reference model (register array + flags) computes
// the expected architectural state at acceptance; a monitor pops expectations
// on every done pulse and checks flags and all registers after writeback.
module tb_alu_exec_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = '0;
  logic [1:0] instr_rd = '0, instr_rs = '0, instr_rt = '0;
  logic       instr_imm_en = 1'b0;
  logic [7:0] instr_imm = '0;
  logic       instr_wb_en = 1'b0;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_zero, alu_carry, alu_negative;
  logic [2:0] flags;
  logic       done;
  logic [1:0] dbg_sel = '0;
  logic [7:0] dbg_data;

  alu_exec_seq dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
    .instr_rt(instr_rt), .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
    .instr_wb_en(instr_wb_en),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_negative(alu_negative),
    .flags(flags), .done(done), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns result and {N,C,Z}
  function automatic void alu_fn(input logic [2:0] op, input logic [7:0] a,
                                 input logic [7:0] b, output logic [7:0] r,
                                 output logic [2:0] f);
    int  s;
    logic c;
    c = 1'b0;
    case (op)
      3'd0: begin s = int'(a) + int'(b); r = 8'(s); c = (s > 255); end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = 8'(int'(a) * 2); c = (a >= 8'd128); end
      default: begin r = a / 8'd2; c = (a % 8'd2) == 8'd1; end
    endcase
    f = {r >= 8'd128, c, r == 8'd0};
  endfunction

  always_comb begin
    logic [7:0] r;
    logic [2:0] f;
    alu_fn(alu_op, alu_a, alu_b, r, f);
    alu_result   = r;
    alu_negative = f[2];
    alu_carry    = f[1];
    alu_zero     = f[0];
  end

  typedef struct {
    logic [7:0] regs [4];
    logic [2:0] flags;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mregs [4];
  logic [2:0] mflags;
  int         nchk = 0;
  int         nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    mflags = 3'b000;
  endtask

  // Called shortly after a negedge. Returns shortly after the negedge that
  // follows the acceptance edge; waited = negedges spent with ready low.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [1:0] rt, input logic imm_en, input logic [7:0] imm,
                       input logic wb_en, input bit keep, output int waited);
    exp_t e;
    logic [7:0] a, b, r;
    logic [2:0] f;
    instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
    instr_imm_en = imm_en; instr_imm = imm; instr_wb_en = wb_en;
    instr_valid = 1'b1;
    waited = 0;
    while (!instr_ready && waited < 40) begin
      @(negedge clk); #1; waited++;
    end
    if (!instr_ready) begin
      chk("accept_timeout", 32'(instr_ready), 32'd1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    a = mregs[rs];
    b = imm_en ? imm : mregs[rt];
    alu_fn(op, a, b, r, f);
    if (wb_en) mregs[rd] = r;
    mflags = f;
    e.regs = mregs;
    e.flags = mflags;
    q.push_back(e);
    #1 instr_valid = keep;
    @(negedge clk); #1;
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1 chk(name, 32'(dbg_data), 32'(mregs[i]));
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin @(negedge clk); n++; end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  // Monitor: on each done pulse, pop and check the post-writeback state.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = q.pop_front();
          @(negedge clk);
          chk("done_one_cycle", 32'(done), 32'd0);
          chk("flags", 32'(flags), 32'(e.flags));
          for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1 chk("reg_after_wb", 32'(dbg_data), 32'(e.regs[i]));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    model_reset();
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    check_regs("rst_reg");
    rst = 1'b0;
    @(negedge clk); #1;
    chk("ready_after_rst", 32'(instr_ready), 32'd1);

    // ADD r1 = r0 + 5, with latency checks
    issue(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 1'b1, 1'b0, w);
    chk("lat_read_done", 32'(done), 32'd0);
    @(negedge clk); #1;
    chk("lat_exec_done", 32'(done), 32'd0);
    @(negedge clk); #1;
    chk("lat_wb_done", 32'(done), 32'd1);
    chk("lat_wb_ready", 32'(instr_ready), 32'd0);
    @(negedge clk); #1;
    chk("lat_ready_again", 32'(instr_ready), 32'd1);
    chk("add_r1", 32'(mregs[1]), 32'h05);

    // Directed plan: flags 011, 110, 010
    issue(3'd0, 2'd2, 2'd1, 2'd0, 1'b1, 8'hFB, 1'b1, 1'b0, w);
    issue(3'd1, 2'd3, 2'd0, 2'd0, 1'b1, 8'h01, 1'b1, 1'b0, w);
    issue(3'd7, 2'd3, 2'd3, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, w);
    drain();
    chk("shr_flags", 32'(flags), 32'b010);
    chk("shr_r3", 32'(mregs[3]), 32'h7F);

    // Compare (wb_en=0) held valid, then XOR waiting behind it
    issue(3'd1, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00, 1'b0, 1'b1, w);
    issue(3'd4, 2'd0, 2'd1, 2'd1, 1'b0, 8'h00, 1'b1, 1'b0, w);
    chk("held_valid_wait", 32'(w), 32'd3);
    drain();
    chk("xor_flags", 32'(flags), 32'b001);

    // Randomised phase
    for (int k = 0; k < 40; k++) begin
      issue(3'($urandom_range(7)), 2'($urandom_range(3)), 2'($urandom_range(3)),
            2'($urandom_range(3)), 1'($urandom_range(1)), 8'($urandom),
            1'($urandom_range(1)), 1'b0, w);
    end
    drain();

    // Reset during EXEC aborts the instruction
    instr_op = 3'd0; instr_rd = 2'd1; instr_rs = 2'd0; instr_rt = 2'd0;
    instr_imm_en = 1'b1; instr_imm = 8'h10; instr_wb_en = 1'b1;
    instr_valid = 1'b1;
    w = 0;
    while (!instr_ready && w < 20) begin @(negedge clk); #1; w++; end
    @(posedge clk);            // acceptance edge
    #1 instr_valid = 1'b0;
    @(posedge clk);            // into EXEC
    #2 rst = 1'b1;
    model_reset();
    @(negedge clk); #1;
    chk("abort_ready", 32'(instr_ready), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    chk("abort_alu_a", 32'(alu_a), 32'd0);
    @(negedge clk); #1;
    chk("abort_no_done", 32'(done), 32'd0);
    check_regs("abort_reg");
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      chk("abort_no_done_after", 32'(done), 32'd0);
    end
    chk("abort_ready_back", 32'(instr_ready), 32'd1);
    issue(3'd0, 2'd2, 2'd0, 2'd0, 1'b1, 8'h33, 1'b1, 1'b0, w);
    drain();
    chk("post_abort_r2", 32'(mregs[2]), 32'h33);
    check_regs("final_reg");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Multi-cycle execute sequencer sitting directly upstream of the 8-bit ALU; also consumes the ALU's outputs.
- Accepts one instruction per valid/ready handshake.
- Reads two operands from an internal 4x8 register file (or substitutes an immediate for the second operand) and drives the ALU.
- Captures the ALU's result and Z/C/N outputs, then writes the result back to the register file and updates a status register.

Parameters:
- NREGS, 4, number of 8-bit general registers; fixed at 4 because of the 2-bit register indices.
- WIDTH, 8, datapath width; must match the ALU.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_op  in  3  ALU opcode: ADD=000, SUB=001, AND=010, OR=011, XOR=100, NOT=101, SHL=110, SHR=111.
- instr_rd  in  2  destination register.
- instr_rs  in  2  first source register; drives ALU a.
- instr_rt  in  2  second source register; drives ALU b when imm_en=0.
- instr_imm_en  in  1  use instr_imm as ALU b instead of register rt.
- instr_imm  in  8  immediate operand.
- instr_wb_en  in  1  1 = write result to rd; 0 = update flags only (compare/test).
- alu_a  out  8  ALU operand a.
- alu_b  out  8  ALU operand b.
- alu_op  out  3  ALU opcode.
- alu_result  in  8  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_zero  in  1  ALU zero flag.
- alu_carry  in  1  ALU carry/borrow flag.
- alu_negative  in  1  ALU negative flag.
- flags  out  3  status register {N, C, Z}.
- done  out  1  high for exactly one cycle, during WB.
- dbg_sel  in  2  debug register select.
- dbg_data  out  8  combinational read of register dbg_sel.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All registers r0..r3 = 0x00; flags = 3'b000.
  - Latched instruction fields and operand registers = 0.
  - alu_a = alu_b = 0x00, alu_op = 000, done = 0, instr_ready = 0 while rst is high.
- FSM states:
  - IDLE: instr_ready=1. On instr_valid & instr_ready at a clock edge, latch all instr_* fields and go to READ.
  - READ: instr_ready=0. Latch opA = reg[rs]; latch opB = imm_en ? imm : reg[rt]. Go to EXEC.
  - EXEC: alu_a=opA, alu_b=opB, alu_op=latched op, all driven from registers. At the edge leaving EXEC, capture alu_result and the three ALU flags into a result register. Go to WB.
  - WB: done=1. At the edge leaving WB:
    - If wb_en=1, write reg[rd] = captured result.
    - Always write flags = captured {N,C,Z}.
    - Go to IDLE.
- Latency: accept edge E0; register and flags update at E3; the result is readable by an instruction accepted at or after E4. Throughput is one instruction per 4 cycles.
- instr_valid held high while not in IDLE is ignored; the instruction must still be present when IDLE returns and is accepted then.
- rd equal to rs or rt: operands are read in READ before writeback, so sources use old values.
- ALU outputs are don't-care outside EXEC and are sampled only at the EXEC exit edge.
- NOT ignores b; the sequencer still drives opB unchanged.
- SUB carry is a borrow (a < b); it is stored unmodified.
- Reset mid-operation aborts the instruction: no register or flag write, no done pulse.
- dbg_data reflects the register state after the most recent edge, with no bypass.

Decomposition:
- Shared package holds:
  - ALU opcode constants (identical codes to the ALU);
  - FSM state encoding IDLE=2'd0, READ=2'd1, EXEC=2'd2, WB=2'd3;
  - flag bit indices FLAG_Z=0, FLAG_C=1, FLAG_N=2.
- One natural sub-module: regfile_4x8, a 4x8 register file with two combinational read ports, one synchronous write port, a debug read port, and asynchronous reset to zero.
- The ALU itself is instantiated alongside, at the next level up, not inside this block.

Test Plan:
- Reset, then ADD rd=1, rs=0, imm_en=1, imm=0x05, wb_en=1 -> done on the 4th cycle after acceptance; r1=0x05; flags=000; instr_ready high again the cycle after done.
- ADD rd=2, rs=1(0x05), imm=0xFB -> r2=0x00, flags {N,C,Z}=011.
- SUB rd=3, rs=0(0x00), imm=0x01 -> r3=0xFF, flags=110. Then SHR rd=3, rs=3 -> r3=0x7F, flags=010.
- SUB with wb_en=0, rd=1, rs=1(0x05), rt=1 -> r1 stays 0x05, flags=001 (Z set).
- instr_valid held high across a busy period with a second instruction XOR rd=0, rs=1, rt=1 -> instr_ready=0 for 3 cycles, then accepted; r0=0x00, flags=001. No double acceptance occurs.
- Assert rst during EXEC of ADD rd=1, imm=0x10 -> FSM in IDLE; all registers 0x00; flags=000; no done pulse; next instruction executes normally.
